net_packet_rx: RTL and testbench

Core-side receiver and decoder for the host network packet stream that programs and controls a core. It sits between the network input and the core's instruction memory, register file, PC and barrier logic. Accepted packets are buffered in order in a small FIFO, and each packet is dispatched as exactly one write or control strobe. The block absorbs register-file port conflicts and never back-pressures the network.

---
 rtl/net_packet_rx_if.sv | 42 ++++
 rtl/net_packet_rx.sv | 162 ++++++++++++++++
 tb/tb_net_packet_rx.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/net_packet_rx_if.sv
// net_packet_rx_if: bundles the network packet input, the instruction-memory
// write port, the register-file write port (with its ready handshake), the
// PC/barrier load port and the sticky status flags of net_packet_rx.
//   master : receiver side (drives strobes/addresses/data/status, reads
//            the packet word and rf_ready_i)
//   slave  : core/network side (drives the packet word and rf_ready_i)
interface net_packet_rx_if #(
  parameter int imem_addr_width_p = 10,
  parameter int rf_addr_width_p   = 6,
  parameter int mask_length_p     = 3
);
  logic [59:0]                  net_packet_flat_i;
  logic                         imem_we_o;
  logic [imem_addr_width_p-1:0] imem_addr_o;
  logic [15:0]                  imem_data_o;
  logic                         rf_we_o;
  logic [rf_addr_width_p-1:0]   rf_addr_o;
  logic [31:0]                  rf_data_o;
  logic                         rf_ready_i;
  logic                         pc_load_o;
  logic [imem_addr_width_p-1:0] pc_o;
  logic [mask_length_p-1:0]     barrier_bits_o;
  logic [mask_length_p-1:0]     barrier_mask_o;
  logic                         overflow_o;
  logic                         addr_err_o;

  modport master (
    input  net_packet_flat_i, rf_ready_i,
    output imem_we_o, imem_addr_o, imem_data_o,
    output rf_we_o, rf_addr_o, rf_data_o,
    output pc_load_o, pc_o, barrier_bits_o, barrier_mask_o,
    output overflow_o, addr_err_o
  );

  modport slave (
    output net_packet_flat_i, rf_ready_i,
    input  imem_we_o, imem_addr_o, imem_data_o,
    input  rf_we_o, rf_addr_o, rf_data_o,
    input  pc_load_o, pc_o, barrier_bits_o, barrier_mask_o,
    input  overflow_o, addr_err_o
  );
endinterface

// File: rtl/net_packet_rx.sv
// net_packet_rx: core-side receiver/decoder for the host network packet
// stream. Packets addressed to this core are queued in arrival order in a
// small FIFO and each one is dispatched as a single instruction write,
// register write, PC load or barrier-mask update. Never back-pressures the
// network; drops (FIFO full) and bad REG addresses raise sticky flags.
// Ports:
//   clk   : clock, all state updates on posedge
//   reset : asynchronous, active-low
//   bus   : net_packet_rx_if.master (packet in, imem/rf/pc ports, status)
// imem_addr_width_p must not exceed the 10-bit net_addr field.
module net_packet_rx #(
  parameter logic [9:0] id_p              = 10'd1,
  parameter int         imem_addr_width_p = 10,
  parameter int         rf_addr_width_p   = 6,
  parameter int         mask_length_p     = 3,
  parameter int         fifo_depth_p      = 4
) (
  input  logic             clk,
  input  logic             reset,
  net_packet_rx_if.master  bus
);

  localparam int ptr_w = $clog2(fifo_depth_p);
  localparam int cnt_w = ptr_w + 1;

  localparam logic [2:0] OP_INSTR = 3'd1;
  localparam logic [2:0] OP_REG   = 3'd2;
  localparam logic [2:0] OP_PC    = 3'd3;
  localparam logic [2:0] OP_BAR   = 3'd4;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] WAIT_RF = 2'd2;

  // ---- stage p0: decode of the raw packet word ----
  logic [9:0]  id_p0;
  logic [2:0]  op_p0;
  logic [31:0] data_p0;
  logic [9:0]  addr_p0;
  logic        accept_p0;
  logic        addr_oob_p0;
  logic        vld_p0;
  logic        unused_reserved;

  assign id_p0   = bus.net_packet_flat_i[59:50];
  assign op_p0   = bus.net_packet_flat_i[49:47];
  assign data_p0 = bus.net_packet_flat_i[41:10];
  assign addr_p0 = bus.net_packet_flat_i[9:0];
  assign unused_reserved = ^bus.net_packet_flat_i[46:42];

  // Opcodes 5-7 behave like NULL, so only 1..4 are accepted.
  assign accept_p0   = (id_p0 == id_p) && (op_p0 >= OP_INSTR) && (op_p0 <= OP_BAR);
  assign addr_oob_p0 = accept_p0 && (op_p0 == OP_REG) &&
                       ((addr_p0 >> rf_addr_width_p) != 10'd0);
  assign vld_p0      = accept_p0 && !addr_oob_p0;

  // ---- packet FIFO ----
  logic [2:0]       fifo_op   [fifo_depth_p];
  logic [31:0]      fifo_data [fifo_depth_p];
  logic [9:0]       fifo_addr [fifo_depth_p];
  logic [ptr_w-1:0] wr_ptr, rd_ptr;
  logic [cnt_w-1:0] count;
  logic             full, empty, push, pop, drop;

  // ---- stage p1: output/dispatch registers ----
  logic [1:0]               state, state_nxt;
  logic [2:0]               op_p1;
  logic [31:0]              data_p1;
  logic [9:0]               addr_p1;
  logic [mask_length_p-1:0] barrier_mask_p1;
  logic                     overflow_q, addr_err_q;
  logic                     busy, done;

  assign full  = (count == cnt_w'(fifo_depth_p));
  assign empty = (count == '0);

  // A REG write is only done on a ready cycle; every other op finishes in
  // its single ISSUE cycle. A completing entry lets the next one pop at the
  // same edge, which gives one packet per cycle.
  assign busy = (state == ISSUE) || (state == WAIT_RF);
  assign done = busy && ((op_p1 != OP_REG) || bus.rf_ready_i);
  assign pop  = !empty && ((state == IDLE) || done);
  // When full, an arrival still fits if the head leaves at the same edge.
  assign push = vld_p0 && (!full || pop);
  assign drop = vld_p0 && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr]   <= op_p0;
      fifo_data[wr_ptr] <= data_p0;
      fifo_addr[wr_ptr] <= addr_p0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:          if (!empty) state_nxt = ISSUE;
      ISSUE, WAIT_RF: begin
        if (done) state_nxt = empty ? IDLE : ISSUE;
        else      state_nxt = WAIT_RF;
      end
      default:       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      op_p1           <= '0;
      data_p1         <= '0;
      addr_p1         <= '0;
      barrier_mask_p1 <= '0;
      overflow_q      <= 1'b0;
      addr_err_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        op_p1   <= fifo_op[rd_ptr];
        data_p1 <= fifo_data[rd_ptr];
        addr_p1 <= fifo_addr[rd_ptr];
        // The mask is loaded as the BAR entry leaves the FIFO.
        if (fifo_op[rd_ptr] == OP_BAR)
          barrier_mask_p1 <= fifo_data[rd_ptr][mask_length_p-1:0];
      end
      if (drop)        overflow_q <= 1'b1;
      if (addr_oob_p0) addr_err_q <= 1'b1;
    end
  end

  // Strobes come from registered state only, so the address/data beside
  // them stay stable for the whole strobe cycle.
  assign bus.imem_we_o      = (state == ISSUE) && (op_p1 == OP_INSTR);
  assign bus.imem_addr_o    = addr_p1[imem_addr_width_p-1:0];
  assign bus.imem_data_o    = data_p1[15:0];
  assign bus.rf_we_o        = busy && (op_p1 == OP_REG);
  assign bus.rf_addr_o      = addr_p1[rf_addr_width_p-1:0];
  assign bus.rf_data_o      = data_p1;
  assign bus.pc_load_o      = (state == ISSUE) && (op_p1 == OP_PC);
  assign bus.pc_o           = addr_p1[imem_addr_width_p-1:0];
  assign bus.barrier_bits_o = data_p1[mask_length_p-1:0];
  assign bus.barrier_mask_o = barrier_mask_p1;
  assign bus.overflow_o     = overflow_q;
  assign bus.addr_err_o     = addr_err_q;

endmodule

// File: tb/tb_net_packet_rx.sv
module tb_net_packet_rx;

  localparam logic [2:0] OP_NULL  = 3'd0;
  localparam logic [2:0] OP_INSTR = 3'd1;
  localparam logic [2:0] OP_REG   = 3'd2;
  localparam logic [2:0] OP_PC    = 3'd3;
  localparam logic [2:0] OP_BAR   = 3'd4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  net_packet_rx_if bus_if ();

  net_packet_rx dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [59:0] pkt(input logic [9:0] id, input logic [2:0] op,
                                      input logic [31:0] data, input logic [9:0] addr);
    return {id, op, 5'b0, data, addr};
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    bus_if.rf_ready_i = 1'b1;
    bus_if.net_packet_flat_i = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus_if.imem_we_o !== 1'b0) begin failures++; $display("FAIL reset_imem_we got=%b want=0", bus_if.imem_we_o); end
    checks++; if (bus_if.rf_we_o !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%b want=0", bus_if.rf_we_o); end
    checks++; if (bus_if.pc_load_o !== 1'b0) begin failures++; $display("FAIL reset_pc_load got=%b want=0", bus_if.pc_load_o); end
    checks++; if ({bus_if.imem_addr_o, bus_if.imem_data_o, bus_if.rf_addr_o, bus_if.rf_data_o, bus_if.pc_o, bus_if.barrier_bits_o} !== '0)
      begin failures++; $display("FAIL reset_addr_data got=%h want=0", {bus_if.imem_addr_o, bus_if.imem_data_o, bus_if.rf_addr_o, bus_if.rf_data_o, bus_if.pc_o, bus_if.barrier_bits_o}); end
    checks++; if ({bus_if.barrier_mask_o, bus_if.overflow_o, bus_if.addr_err_o} !== 5'b0)
      begin failures++; $display("FAIL reset_status got=%b want=00000", {bus_if.barrier_mask_o, bus_if.overflow_o, bus_if.addr_err_o}); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_instr();
    bus_if.net_packet_flat_i = pkt(10'd1, OP_INSTR, 32'h0000_ABCD, 10'd5);
    @(negedge clk);
    bus_if.net_packet_flat_i = '0;
    checks++; if (bus_if.imem_we_o !== 1'b0) begin failures++; $display("FAIL instr_early got=%b want=0", bus_if.imem_we_o); end
    @(negedge clk);
    checks++; if (bus_if.imem_we_o !== 1'b1) begin failures++; $display("FAIL instr_we got=%b want=1", bus_if.imem_we_o); end
    checks++; if (bus_if.imem_addr_o !== 10'd5) begin failures++; $display("FAIL instr_addr got=%0d want=5", bus_if.imem_addr_o); end
    checks++; if (bus_if.imem_data_o !== 16'hABCD) begin failures++; $display("FAIL instr_data got=%h want=abcd", bus_if.imem_data_o); end
    @(negedge clk);
    checks++; if (bus_if.imem_we_o !== 1'b0) begin failures++; $display("FAIL instr_one_cycle got=%b want=0", bus_if.imem_we_o); end
  endtask

  task automatic test_back_to_back();
    int nwr = 0;
    int first = -1;
    int last = -1;
    bus_if.rf_ready_i = 1'b1;
    for (int it = 0; it < 20; it++) begin
      if (bus_if.rf_we_o === 1'b1) begin
        nwr++;
        if (first < 0) first = it;
        last = it;
        checks++; if (bus_if.rf_addr_o !== 6'(nwr)) begin failures++; $display("FAIL b2b_addr got=%0d want=%0d", bus_if.rf_addr_o, nwr); end
        checks++; if (bus_if.rf_data_o !== 32'h100 + 32'(nwr)) begin failures++; $display("FAIL b2b_data got=%h want=%h", bus_if.rf_data_o, 32'h100 + 32'(nwr)); end
      end
      if (it < 12) bus_if.net_packet_flat_i = pkt(10'd1, OP_REG, 32'h100 + 32'(it + 1), 10'(it + 1));
      else         bus_if.net_packet_flat_i = '0;
      @(negedge clk);
    end
    checks++; if (nwr !== 12) begin failures++; $display("FAIL b2b_count got=%0d want=12", nwr); end
    checks++; if (first !== 2 || last !== 13) begin failures++; $display("FAIL b2b_span got=%0d..%0d want=2..13", first, last); end
    checks++; if (bus_if.overflow_o !== 1'b0) begin failures++; $display("FAIL b2b_overflow got=%b want=0", bus_if.overflow_o); end
  endtask

  task automatic test_rf_stall();
    int nwr = 0;
    int last_rf = -1;
    int npc = 0;
    int pc_it = -1;
    for (int it = 0; it < 10; it++) begin
      bus_if.rf_ready_i = (it >= 5);
      if (bus_if.rf_we_o === 1'b1) begin
        nwr++;
        last_rf = it;
        checks++; if (bus_if.rf_addr_o !== 6'd20 || bus_if.rf_data_o !== 32'd1)
          begin failures++; $display("FAIL stall_hold got=%0d/%h want=20/1", bus_if.rf_addr_o, bus_if.rf_data_o); end
      end
      if (bus_if.pc_load_o === 1'b1) begin
        npc++;
        pc_it = it;
        checks++; if (bus_if.pc_o !== 10'd0 || bus_if.barrier_bits_o !== 3'b010)
          begin failures++; $display("FAIL stall_pc got=%0d/%b want=0/010", bus_if.pc_o, bus_if.barrier_bits_o); end
      end
      if (it == 0)      bus_if.net_packet_flat_i = pkt(10'd1, OP_REG, 32'd1, 10'd20);
      else if (it == 1) bus_if.net_packet_flat_i = pkt(10'd1, OP_PC, 32'd2, 10'd0);
      else              bus_if.net_packet_flat_i = '0;
      @(negedge clk);
    end
    checks++; if (nwr !== 4 || last_rf !== 5) begin failures++; $display("FAIL stall_rf_cycles got=%0d@%0d want=4@5", nwr, last_rf); end
    checks++; if (npc !== 1 || pc_it !== 6) begin failures++; $display("FAIL stall_pc_order got=%0d@%0d want=1@6", npc, pc_it); end
  endtask

  task automatic test_overflow();
    int nwr = 0;
    for (int it = 0; it < 20; it++) begin
      bus_if.rf_ready_i = (it >= 8);
      if (it == 5) begin
        checks++; if (bus_if.overflow_o !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b want=0", bus_if.overflow_o); end
      end
      if (it == 6) begin
        checks++; if (bus_if.overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b want=1", bus_if.overflow_o); end
      end
      if (bus_if.rf_we_o === 1'b1 && bus_if.rf_ready_i === 1'b1) begin
        checks++; if (bus_if.rf_addr_o !== 6'(30 + nwr)) begin failures++; $display("FAIL ovf_order got=%0d want=%0d", bus_if.rf_addr_o, 30 + nwr); end
        nwr++;
      end
      if (it < 6) bus_if.net_packet_flat_i = pkt(10'd1, OP_REG, 32'hC0 + 32'(it), 10'(30 + it));
      else        bus_if.net_packet_flat_i = '0;
      @(negedge clk);
    end
    checks++; if (nwr !== 5) begin failures++; $display("FAIL ovf_writes got=%0d want=5", nwr); end
    checks++; if (bus_if.overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b want=1", bus_if.overflow_o); end
  endtask

  task automatic test_bar_filter();
    int nstrobe = 0;
    bus_if.rf_ready_i = 1'b1;
    for (int it = 0; it < 10; it++) begin
      if (bus_if.imem_we_o === 1'b1 || bus_if.rf_we_o === 1'b1 || bus_if.pc_load_o === 1'b1) nstrobe++;
      if (it == 3) begin
        checks++; if (bus_if.barrier_mask_o !== 3'b000) begin failures++; $display("FAIL bar_early got=%b want=000", bus_if.barrier_mask_o); end
      end
      if (it == 4) begin
        checks++; if (bus_if.barrier_mask_o !== 3'b111) begin failures++; $display("FAIL bar_load got=%b want=111", bus_if.barrier_mask_o); end
      end
      case (it)
        0: bus_if.net_packet_flat_i = pkt(10'd2, OP_INSTR, 32'h1234, 10'd7);
        1: bus_if.net_packet_flat_i = pkt(10'd1, OP_NULL, 32'h55, 10'd3);
        2: bus_if.net_packet_flat_i = pkt(10'd1, OP_BAR, 32'd7, 10'd0);
        3: bus_if.net_packet_flat_i = pkt(10'd2, OP_REG, 32'h9, 10'd9);
        4: bus_if.net_packet_flat_i = pkt(10'd2, OP_BAR, 32'd2, 10'd0);
        5: bus_if.net_packet_flat_i = pkt(10'd1, 3'd6, 32'h77, 10'd1);
        6: bus_if.net_packet_flat_i = pkt(10'd2, OP_PC, 32'd1, 10'd4);
        default: bus_if.net_packet_flat_i = '0;
      endcase
      @(negedge clk);
    end
    checks++; if (nstrobe !== 0) begin failures++; $display("FAIL bar_no_strobe got=%0d want=0", nstrobe); end
    checks++; if (bus_if.barrier_mask_o !== 3'b111) begin failures++; $display("FAIL bar_final got=%b want=111", bus_if.barrier_mask_o); end
  endtask

  task automatic test_addr_err_reset();
    int nwr = 0;
    bus_if.rf_ready_i = 1'b1;
    for (int it = 0; it < 5; it++) begin
      if (bus_if.rf_we_o === 1'b1) nwr++;
      bus_if.net_packet_flat_i = (it == 0) ? pkt(10'd1, OP_REG, 32'h1, 10'd64) : '0;
      @(negedge clk);
    end
    checks++; if (nwr !== 0) begin failures++; $display("FAIL oob_no_write got=%0d want=0", nwr); end
    checks++; if (bus_if.addr_err_o !== 1'b1) begin failures++; $display("FAIL oob_addr_err got=%b want=1", bus_if.addr_err_o); end

    bus_if.rf_ready_i = 1'b0;
    bus_if.net_packet_flat_i = pkt(10'd1, OP_REG, 32'h55, 10'd3);
    @(negedge clk);
    bus_if.net_packet_flat_i = pkt(10'd1, OP_REG, 32'h66, 10'd4);
    @(negedge clk);
    bus_if.net_packet_flat_i = '0;
    checks++; if (bus_if.rf_we_o !== 1'b1) begin failures++; $display("FAIL rst_stall_setup got=%b want=1", bus_if.rf_we_o); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({bus_if.rf_we_o, bus_if.imem_we_o, bus_if.pc_load_o} !== 3'b000)
      begin failures++; $display("FAIL rst_async_strobes got=%b want=000", {bus_if.rf_we_o, bus_if.imem_we_o, bus_if.pc_load_o}); end
    checks++; if (bus_if.rf_addr_o !== 6'd0 || bus_if.rf_data_o !== 32'd0)
      begin failures++; $display("FAIL rst_async_data got=%0d/%h want=0/0", bus_if.rf_addr_o, bus_if.rf_data_o); end
    checks++; if ({bus_if.barrier_mask_o, bus_if.overflow_o, bus_if.addr_err_o} !== 5'b0)
      begin failures++; $display("FAIL rst_async_status got=%b want=00000", {bus_if.barrier_mask_o, bus_if.overflow_o, bus_if.addr_err_o}); end
    @(negedge clk);
    reset = 1'b1;
    bus_if.rf_ready_i = 1'b1;
    nwr = 0;
    for (int it = 0; it < 6; it++) begin
      @(negedge clk);
      if (bus_if.rf_we_o === 1'b1) nwr++;
    end
    checks++; if (nwr !== 0) begin failures++; $display("FAIL rst_fifo_flushed got=%0d want=0", nwr); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_instr();
    test_back_to_back();
    test_rf_stall();
    test_overflow();
    test_bar_filter();
    test_addr_err_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
